alu_rr_scheduler: RTL and testbench
===================================

Name: alu_rr_scheduler

Overview:
- Shares one instance of the team's 4-bit combinational ALU between NUM_REQ requesters using round-robin arbitration.
- Each requester issues an operation (A, B, op select) over a valid/ready handshake.
- The scheduler drives the ALU operand and select inputs from registers, then captures Result/CarryOut into a response register.
- The response is returned on a single valid/ready response channel tagged with the requester id.
- Sits at subsystem top, beside the ALU instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of rsp_id; must equal ceil(log2(NUM_REQ)).

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high.
- req_a  in  4*NUM_REQ  operand A; requester i in bits [4i+3:4i].
- req_b  in  4*NUM_REQ  operand B, same packing.
- req_sel  in  3*NUM_REQ  ALU op select; requester i in bits [3i+2:3i].
- alu_a  out  4  registered operand A to ALU.
- alu_b  out  4  registered operand B to ALU.
- alu_sel  out  3  registered op select to ALU.
- alu_result  in  4  ALU Result.
- alu_carry  in  1  ALU CarryOut.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  ID_W  index of the requester that issued the op.
- rsp_result  out  4  captured result.
- rsp_carry  out  1  captured carry/borrow (0 for ops other than add/sub).

Behaviour:
- Reset: clk edge with rst_n=0 clears all of the following:
  - alu_a, alu_b, alu_sel, rsp_valid, rsp_id, rsp_result, rsp_carry, req_ready=0.
  - state=IDLE.
  - last_grant=NUM_REQ-1, so requester 0 wins first.
- Reset mid-operation: the in-flight op is discarded and no response is issued. The requester sees its handshake as completed.
- FSM IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - If any req_valid, grant g = first set bit scanning upward from last_grant+1, wrapping modulo NUM_REQ.
  - req_ready[g]=1 combinationally that cycle; the handshake completes that cycle.
  - On the edge: alu_a/alu_b/alu_sel <= requester g payload, rsp_id <= g, last_grant <= g, state <= EXEC.
  - No req_valid: remain in IDLE, all req_ready=0.
- EXEC (ALU settle cycle):
  - On the edge: rsp_result <= alu_result, rsp_carry <= alu_carry, rsp_valid <= 1, state <= RESP.
- RESP:
  - rsp_* held stable while rsp_ready=0.
  - When rsp_valid & rsp_ready: rsp_valid <= 0, state <= IDLE.
  - alu_* hold their value until the next grant.
- req_ready=0 in EXEC and RESP regardless of req_valid.
- Latency: request accept at cycle N -> rsp_valid high at cycle N+2. Minimum issue interval is 3 cycles.
- Requester rules:
  - Must hold its payload stable while req_valid=1 and req_ready=0.
  - May drop req_valid without acceptance; no grant is then made to it.
- Simultaneous events: a request arriving in the same cycle rsp_ready completes is not accepted until the next IDLE cycle.
- Fairness: with all requesters continuously valid, grants cycle 0,1,...,NUM_REQ-1,0. No requester waits more than NUM_REQ grants.
- Width rules: no arithmetic in this block. Carry/borrow semantics are the ALU's: 5-bit add/sub, carry forced to 0 for sel>=3'b010.
- Unused high ID bits: not applicable, since ID_W is exact.

Decomposition:
- Shared package alu_pkg holds:
  - op-code constants ALU_ADD=0, ALU_SUB=1, ALU_AND=2, ALU_OR=3, ALU_XOR=4, ALU_SHL=5, ALU_SHR=6, ALU_NOT=7;
  - ALU_DATA_W=4, ALU_SEL_W=3;
  - the FSM state typedef (IDLE, EXEC, RESP).
- One sub-module, rr_arbiter:
  - parameter NUM_REQ;
  - inputs req vector and last_grant;
  - outputs one-hot grant and encoded index;
  - purely combinational.
- The ALU itself is instantiated at the level above and connected through the alu_* ports.

Test Plan:
- Add: req0 a=0101 b=0011 sel=000 -> two cycles after accept, rsp_id=0, rsp_result=1000, rsp_carry=0.
- Add overflow: req2 a=1001 b=1000 sel=000 -> rsp_result=0001, rsp_carry=1.
- Subtract:
  - req1 a=0110 b=0010 sel=001 -> rsp_result=0100, carry=0.
  - a=0010 b=0110 sel=001 -> rsp_result=1100, carry=1.
- Round-robin: req0..req3 all held valid with distinct ops for 12 grants -> rsp_id sequence 0,1,2,3,0,1,2,3,0,1,2,3; never two req_ready bits high.
- Backpressure: rsp_ready=0 for 5 cycles during RESP on an XOR 1100^1010 -> rsp_valid=1 and rsp_result=0110 held stable, all req_ready=0. Release -> next grant the cycle after return to IDLE.
- Reset mid-op: rst_n=0 for one edge while in EXEC -> next cycle rsp_valid=0, alu_*=0, state IDLE. With req0 and req1 then valid, req0 is granted first.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared ALU op-codes, data widths and scheduler FSM states.
// Revision    : 1.0
// ============================================================================
package alu_pkg;

    localparam int ALU_DATA_W = 4;
    localparam int ALU_SEL_W  = 3;

    localparam logic [ALU_SEL_W-1:0] ALU_ADD = 3'd0;
    localparam logic [ALU_SEL_W-1:0] ALU_SUB = 3'd1;
    localparam logic [ALU_SEL_W-1:0] ALU_AND = 3'd2;
    localparam logic [ALU_SEL_W-1:0] ALU_OR  = 3'd3;
    localparam logic [ALU_SEL_W-1:0] ALU_XOR = 3'd4;
    localparam logic [ALU_SEL_W-1:0] ALU_SHL = 3'd5;
    localparam logic [ALU_SEL_W-1:0] ALU_SHR = 3'd6;
    localparam logic [ALU_SEL_W-1:0] ALU_NOT = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick, scanning upward from last_grant+1.
// Revision    : 1.0
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic             w_found;
    logic [IDX_W-1:0] w_idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        w_found   = 1'b0;
        w_idx     = '0;
        // Offsets 1..NUM_REQ visit every requester once, last_grant itself last.
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_idx = IDX_W'((int'(last_grant) + i) % NUM_REQ);
            if (!w_found && req[w_idx]) begin
                w_found        = 1'b1;
                grant[w_idx]   = 1'b1;
                grant_idx      = w_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : alu_rr_scheduler
// Description : Round-robin sharing of one external 4-bit ALU among NUM_REQ requesters.
// Revision    : 1.0
// ============================================================================
module alu_rr_scheduler
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [ALU_DATA_W*NUM_REQ-1:0] req_a,
    input  logic [ALU_DATA_W*NUM_REQ-1:0] req_b,
    input  logic [ALU_SEL_W*NUM_REQ-1:0]  req_sel,
    output logic [ALU_DATA_W-1:0]         alu_a,
    output logic [ALU_DATA_W-1:0]         alu_b,
    output logic [ALU_SEL_W-1:0]          alu_sel,
    input  logic [ALU_DATA_W-1:0]         alu_result,
    input  logic                          alu_carry,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [ID_W-1:0]               rsp_id,
    output logic [ALU_DATA_W-1:0]         rsp_result,
    output logic                          rsp_carry
);

    sched_state_t          r_state;
    sched_state_t          w_state_next;
    logic                  w_accept;
    logic [ID_W-1:0]       r_last_grant;
    logic [NUM_REQ-1:0]    w_grant;
    logic [ID_W-1:0]       w_grant_idx;
    logic [ALU_DATA_W-1:0] w_pay_a;
    logic [ALU_DATA_W-1:0] w_pay_b;
    logic [ALU_SEL_W-1:0]  w_pay_sel;
    logic [ALU_DATA_W-1:0] r_alu_a;
    logic [ALU_DATA_W-1:0] r_alu_b;
    logic [ALU_SEL_W-1:0]  r_alu_sel;
    logic                  r_rsp_valid;
    logic [ID_W-1:0]       r_rsp_id;
    logic [ALU_DATA_W-1:0] r_rsp_result;
    logic                  r_rsp_carry;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (ID_W)
    ) u_arb (
        .req        (req_valid),
        .last_grant (r_last_grant),
        .grant      (w_grant),
        .grant_idx  (w_grant_idx)
    );

    always_comb begin
        w_pay_a   = '0;
        w_pay_b   = '0;
        w_pay_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_pay_a   = req_a[i*ALU_DATA_W +: ALU_DATA_W];
                w_pay_b   = req_b[i*ALU_DATA_W +: ALU_DATA_W];
                w_pay_sel = req_sel[i*ALU_SEL_W +: ALU_SEL_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                if (|req_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = EXEC;
                end
            end
            EXEC:    w_state_next = RESP;
            RESP:    if (rsp_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Grants are only ever visible while idle; the arbiter output is zero without requests.
    assign req_ready = (r_state == IDLE) ? w_grant : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_sel    <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= '0;
            r_rsp_result <= '0;
            r_rsp_carry  <= 1'b0;
            r_last_grant <= ID_W'(NUM_REQ - 1);
        end else begin
            if (w_accept) begin
                r_alu_a      <= w_pay_a;
                r_alu_b      <= w_pay_b;
                r_alu_sel    <= w_pay_sel;
                r_rsp_id     <= w_grant_idx;
                r_last_grant <= w_grant_idx;
            end
            if (r_state == EXEC) begin
                r_rsp_result <= alu_result;
                r_rsp_carry  <= alu_carry;
                r_rsp_valid  <= 1'b1;
            end
            if (r_state == RESP && rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_sel    = r_alu_sel;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_result = r_rsp_result;
    assign rsp_carry  = r_rsp_carry;

endmodule
`default_nettype wire

// File: tb/tb_alu_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_rr_scheduler
// Description : Directed + random bench with a behavioural ALU and arbitration model.
// Revision    : 1.0
// ============================================================================
module tb_alu_rr_scheduler;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NUM_REQ-1:0]    req_valid = '0;
    logic [NUM_REQ-1:0]    req_ready;
    logic [4*NUM_REQ-1:0]  req_a = '0;
    logic [4*NUM_REQ-1:0]  req_b = '0;
    logic [3*NUM_REQ-1:0]  req_sel = '0;
    logic [3:0]            alu_a, alu_b, alu_result;
    logic [2:0]            alu_sel;
    logic                  alu_carry;
    logic                  rsp_valid;
    logic                  rsp_ready = 1'b0;
    logic [ID_W-1:0]       rsp_id;
    logic [3:0]            rsp_result;
    logic                  rsp_carry;

    int n_vec = 0;
    int n_err = 0;
    int model_last = NUM_REQ - 1;

    always #5 clk = ~clk;

    alu_rr_scheduler #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_result(alu_result), .alu_carry(alu_carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_carry(rsp_carry)
    );

    // Reference ALU: integer add/sub with carry/borrow, logic ops carry 0.
    function automatic logic [4:0] alu_ref(input logic [3:0] a, input logic [3:0] b,
                                           input logic [2:0] sel);
        int s;
        case (sel)
            3'd0: begin s = int'(a) + int'(b); return {(s > 15), 4'(s)}; end
            3'd1: begin s = int'(a) - int'(b); return {(s < 0), 4'(s)}; end
            3'd2: return {1'b0, a & b};
            3'd3: return {1'b0, a | b};
            3'd4: return {1'b0, a ^ b};
            3'd5: return {1'b0, 4'(a << 1)};
            3'd6: return {1'b0, 4'(a >> 1)};
            default: return {1'b0, ~a};
        endcase
    endfunction

    assign {alu_carry, alu_result} = alu_ref(alu_a, alu_b, alu_sel);

    function automatic int pick(input logic [NUM_REQ-1:0] v);
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (v[(model_last + i) % NUM_REQ]) return (model_last + i) % NUM_REQ;
        end
        return -1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] b,
                           input logic [2:0] sel);
        req_a[i*4 +: 4]   = a;
        req_b[i*4 +: 4]   = b;
        req_sel[i*3 +: 3] = sel;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        step();
        step();
        rst_n      = 1'b1;
        model_last = NUM_REQ - 1;
    endtask

    // One full transaction from an IDLE cycle through response retirement.
    task automatic run_txn(input logic [NUM_REQ-1:0] valid, input int bp, input logic drop);
        int         g;
        logic [3:0] ea, eb;
        logic [2:0] es;
        logic [4:0] er;
        req_valid = valid;
        #1;
        check("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
        if (valid == '0) begin
            check("idle_ready", 32'(req_ready), 32'd0);
            step();
            check("idle_rsp_valid", 32'(rsp_valid), 32'd0);
            return;
        end
        g = pick(valid);
        check("grant", 32'(req_ready), 32'(1) << g);
        ea = req_a[g*4 +: 4];
        eb = req_b[g*4 +: 4];
        es = req_sel[g*3 +: 3];
        er = alu_ref(ea, eb, es);
        step();
        model_last = g;
        if (drop) req_valid = '0;
        check("exec_rsp_valid", 32'(rsp_valid), 32'd0);
        check("exec_ready", 32'(req_ready), 32'd0);
        check("alu_a", 32'(alu_a), 32'(ea));
        check("alu_b", 32'(alu_b), 32'(eb));
        check("alu_sel", 32'(alu_sel), 32'(es));
        step();
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("rsp_id", 32'(rsp_id), 32'(g));
        check("rsp_result", 32'(rsp_result), 32'(er[3:0]));
        check("rsp_carry", 32'(rsp_carry), 32'(er[4]));
        check("resp_ready", 32'(req_ready), 32'd0);
        for (int k = 0; k < bp; k++) begin
            step();
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_result", 32'(rsp_result), 32'(er[3:0]));
            check("bp_rsp_id", 32'(rsp_id), 32'(g));
            check("bp_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("retire_rsp_valid", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_alu", 32'({alu_a, alu_b, alu_sel}), 32'd0);
        check("rst_rsp", 32'({rsp_id, rsp_result, rsp_carry}), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);

        // Add, add overflow, subtract without and with borrow
        set_req(0, 4'b0101, 4'b0011, 3'b000);
        run_txn(4'b0001, 0, 1'b1);
        set_req(2, 4'b1001, 4'b1000, 3'b000);
        run_txn(4'b0100, 0, 1'b1);
        set_req(1, 4'b0110, 4'b0010, 3'b001);
        run_txn(4'b0010, 1, 1'b1);
        set_req(1, 4'b0010, 4'b0110, 3'b001);
        run_txn(4'b0010, 0, 1'b1);

        // Round-robin with all requesters held valid
        do_reset();
        set_req(0, 4'b0111, 4'b0001, 3'b000);
        set_req(1, 4'b0011, 4'b0101, 3'b001);
        set_req(2, 4'b1100, 4'b1010, 3'b010);
        set_req(3, 4'b1001, 4'b0110, 3'b111);
        for (int n = 0; n < 12; n++) run_txn(4'b1111, 0, 1'b0);
        req_valid = '0;

        // Backpressure on XOR
        set_req(0, 4'b1100, 4'b1010, 3'b100);
        run_txn(4'b0001, 5, 1'b1);

        // Reset while in EXEC
        set_req(0, 4'b0001, 4'b0001, 3'b000);
        set_req(1, 4'b0010, 4'b0001, 3'b000);
        req_valid = 4'b0001;
        #1;
        step();
        rst_n     = 1'b0;
        req_valid = 4'b0011;
        step();
        rst_n      = 1'b1;
        model_last = NUM_REQ - 1;
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_alu", 32'({alu_a, alu_b, alu_sel}), 32'd0);
        check("midrst_ready", 32'(req_ready), 32'b0001);
        run_txn(4'b0011, 0, 1'b1);

        // Randomised traffic
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req_valid[i])
                    set_req(i, 4'($urandom), 4'($urandom), 3'($urandom));
            end
            run_txn(4'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
